// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial-pattern detector.
package seq_det_pkg;

    typedef enum logic {NON_OVERLAP, OVERLAP} ovl_mode_t;

    typedef enum logic {FILLING, ARMED} det_state_t;

    function automatic int fill_w(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky all-ones flag and synchronous clear.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             sat
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            // A clear coinciding with an increment counts that event.
            cnt_d = inc ? WIDTH'(1) : '0;
            sat_d = 1'b0;
        end else if (inc) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == '1) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: registered match pulse plus saturating match count,
// with overlapping / non-overlapping modes and an input-valid enable.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W   = 3,
    parameter     PATTERN = 3'b110,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             ovl,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             sat
);

    localparam int             FW   = fill_w(PAT_W);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);
    localparam logic [PAT_W-1:0] PAT = PAT_W'(PATTERN);

    if (PAT_W < 2 || $bits(PATTERN) != PAT_W) begin : g_bad_param
        $error("seq_detector_param: PAT_W must be >= 2 and match the width of PATTERN");
    end

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             out_q, out_d;
    logic [PAT_W-1:0] shifted;
    logic             match;
    det_state_t       state;

    assign shifted = {hist_q[PAT_W-2:0], in};

    always_comb begin
        state = (fill_q == FULL) ? ARMED : FILLING;
    end

    // The bit arriving this edge completes the window once PAT_W-1 are held.
    assign match = en && (shifted == PAT) &&
                   (state == ARMED || fill_q == FULL - 1'b1);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        if (en) begin
            hist_d = shifted;
            if (match) begin
                out_d = 1'b1;
                if (ovl_mode_t'(ovl) == NON_OVERLAP) begin
                    fill_d = '0;
                end
            end else if (state == FILLING) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .inc(match),
        .cnt(match_cnt),
        .sat(sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: four detector configurations share one stimulus stream and
// are checked against a stream-history reference model.
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, din, en, ovl, clr;
    logic [3:0] out_w, sat_w;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic [3:0] c3;

    seq_detector_param #(.PAT_W(3), .PATTERN(3'b110), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in(din), .en(en), .ovl(ovl), .clr(clr),
        .out(out_w[0]), .match_cnt(c0), .sat(sat_w[0]));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in(din), .en(en), .ovl(ovl), .clr(clr),
        .out(out_w[1]), .match_cnt(c1), .sat(sat_w[1]));
    seq_detector_param #(.PAT_W(3), .PATTERN(3'b110), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(din), .en(en), .ovl(ovl), .clr(clr),
        .out(out_w[2]), .match_cnt(c2), .sat(sat_w[2]));
    seq_detector_param #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .in(din), .en(en), .ovl(ovl), .clr(clr),
        .out(out_w[3]), .match_cnt(c3), .sat(sat_w[3]));

    typedef struct packed {
        logic [3:0]      out;
        logic [3:0][7:0] cnt;
        logic [3:0]      sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: full history of valid bits, with the index where the
    // current search began (after reset or a non-overlapping match).
    bit strm [4][8192];
    int n_i     [4];
    int start_i [4];
    int m_i     [4];

    function automatic int pw(int k);
        return (k == 1) ? 4 : 3;
    endfunction

    function automatic int pat(int k);
        case (k)
            1:       return 10;
            3:       return 7;
            default: return 6;
        endcase
    endfunction

    function automatic int cmax(int k);
        case (k)
            2:       return 3;
            3:       return 15;
            default: return 255;
        endcase
    endfunction

    function automatic int act_cnt(int k);
        case (k)
            0:       return int'(c0);
            1:       return int'(c1);
            2:       return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    task automatic check(input string name, input int k, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s[dut%0d] t=%0t: got %0d, expected %0d", name, k, $time, act, expv);
        end
    endtask

    task automatic step(input logic i_in, input logic i_en, input logic i_ovl,
                        input logic i_clr, input logic i_rst);
        exp_t e;
        bit   hit;
        din = i_in; en = i_en; ovl = i_ovl; clr = i_clr; rst = i_rst;
        for (int k = 0; k < 4; k++) begin
            hit = 1'b0;
            if (i_rst) begin
                start_i[k] = n_i[k];
                m_i[k]     = 0;
            end else begin
                if (i_en) begin
                    strm[k][n_i[k]] = i_in;
                    n_i[k]++;
                    if (n_i[k] - start_i[k] >= pw(k)) begin
                        hit = 1'b1;
                        for (int b = 0; b < pw(k); b++)
                            if (strm[k][n_i[k] - pw(k) + b] != bit'((pat(k) >> (pw(k) - 1 - b)) & 1))
                                hit = 1'b0;
                    end
                    if (hit && !i_ovl) start_i[k] = n_i[k];
                end
                if (i_clr) m_i[k] = hit ? 1 : 0;
                else if (hit && m_i[k] < cmax(k)) m_i[k]++;
            end
            e.out[k] = hit;
            e.cnt[k] = 8'(m_i[k]);
            e.sat[k] = (m_i[k] >= cmax(k));
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic feed(input logic [15:0] v, input int len, input logic o, input logic clr_last);
        for (int i = len - 1; i >= 0; i--)
            step(v[i], 1'b1, o, clr_last && (i == 0), 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: every cycle the DUTs present a fresh output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    check("out", k, int'(out_w[k]), int'(e.out[k]));
                    check("match_cnt", k, act_cnt(k), int'(e.cnt[k]));
                    check("sat", k, int'(sat_w[k]), int'(e.sat[k]));
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            n_i[k] = 0; start_i[k] = 0; m_i[k] = 0;
        end
        rst = 1'b1; din = 1'b0; en = 1'b0; ovl = 1'b0; clr = 1'b0;
        @(negedge clk);
        do_reset();
        do_reset();

        feed(16'b110, 3, 1'b0, 1'b0);
        check("d_110_out", 0, int'(out_w[0]), 1);
        check("d_110_cnt", 0, int'(c0), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("d_110_pulse_end", 0, int'(out_w[0]), 0);
        feed(16'b1110, 4, 1'b0, 1'b0);
        check("d_1110_cnt", 0, int'(c0), 2);

        do_reset();
        feed(16'b1010101, 7, 1'b1, 1'b0);
        check("d_1010_ovl_cnt", 1, int'(c1), 2);
        do_reset();
        feed(16'b1010101, 7, 1'b0, 1'b0);
        check("d_1010_novl_cnt", 1, int'(c1), 1);

        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("d_gap_out", 0, int'(out_w[0]), 1);
        check("d_gap_cnt", 0, int'(c0), 1);

        do_reset();
        feed(16'b11, 2, 1'b0, 1'b0);
        do_reset();
        check("d_rst_out", 0, int'(out_w), 0);
        check("d_rst_cnt", 0, int'(c0), 0);
        check("d_rst_sat", 0, int'(sat_w), 0);
        feed(16'b0, 1, 1'b0, 1'b0);
        check("d_rst_partial", 0, int'(c0), 0);
        feed(16'b110, 3, 1'b0, 1'b0);
        check("d_rst_after", 0, int'(c0), 1);

        do_reset();
        repeat (6) feed(16'b110, 3, 1'b0, 1'b0);
        check("d_sat_cnt", 2, int'(c2), 3);
        check("d_sat_flag", 2, int'(sat_w[2]), 1);
        check("d_sat_wide", 0, int'(c0), 6);
        feed(16'b110, 3, 1'b0, 1'b1);
        check("d_clr_cnt", 2, int'(c2), 1);
        check("d_clr_flag", 2, int'(sat_w[2]), 0);

        do_reset();
        feed(16'b11111, 5, 1'b1, 1'b0);
        check("d_ones_ovl", 3, int'(c3), 3);
        do_reset();
        feed(16'b11111, 5, 1'b0, 1'b0);
        check("d_ones_novl", 3, int'(c3), 1);

        for (int i = 0; i < 1500; i++)
            step(1'($urandom), $urandom_range(0, 9) < 8, 1'($urandom),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 0, exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial-pattern detector: the next generation of the fixed 3-bit "110" Moore detector. The block scans a 1-bit serial stream for a compile-time pattern of any width, supports overlapping and non-overlapping match modes, and qualifies input bits with an enable. It keeps a saturating match counter for status readout. It sits on the serial-input side of the design and feeds match pulses and counts to downstream control logic.

## Interface
- `PAT_W`, 3, pattern length in bits (≥2)
- `PATTERN`, 3'b110, pattern to detect; MSB is the first bit received
- `CNT_W`, 8, match-counter width
- `clk` input 1: single clock; all logic on posedge
- `rst` input 1: synchronous, active-high reset
- `in` input 1: serial data bit
- `en` input 1: `in` is valid this cycle
- `ovl` input 1: 1 = overlapping matches, 0 = non-overlapping
- `clr` input 1: synchronous clear of `match_cnt` and `sat`
- `out` output 1: registered match pulse
- `match_cnt` output CNT_W: number of matches since reset/clear, saturating
- `sat` output 1: sticky flag, set when `match_cnt` has reached all-ones

## Operation
- `hist[PAT_W-1:0]` shift register; on an edge with `en`=1: `hist <= {hist[PAT_W-2:0], in}`, newest bit in LSB.
- `fill` counter, width $clog2(PAT_W+1); it counts valid bits held and saturates at PAT_W.
- Match condition, evaluated on an `en`=1 edge using the post-shift value: `{hist[PAT_W-2:0], in} == PATTERN` and `fill+1 >= PAT_W`.
- On a match:
  - `out` <= 1
  - `match_cnt` increments
  - if `ovl`=0, `fill` <= 0, so the next match needs PAT_W fresh bits
  - if `ovl`=1, `fill` is kept
- State machine states, defined by `fill`:
  - FILLING while `fill` < PAT_W
  - ARMED while `fill` = PAT_W
  - A non-overlap match returns to FILLING with `fill` = 0.
- `en`=0:
  - `hist` and `fill` hold.
  - `out` <= 0.
- `ovl` is sampled only on match edges. A mode change takes effect at the next match.
- Counter:
  - At all-ones it holds, and `sat` <= 1.
  - `sat` stays set until `clr` or `rst`.
  - If `clr` and a match occur on the same edge, `match_cnt` <= 1 and `sat` <= 0.
- `rst` behaviour:
  - It overrides everything, including mid-pattern.
  - Reset values: `hist`=0, `fill`=0, `out`=0, `match_cnt`=0, `sat`=0.
  - A partial pattern received before reset never contributes to a match.

## Timing
- Moore-style output. `out` is high for exactly one cycle, the cycle after the edge that sampled the final pattern bit. With the default PATTERN this matches the fixed "110" detector cycle-for-cycle.
- `match_cnt` updates on the same edge that sets `out`, so both are visible in the same cycle.
- Back-to-back matches in overlap mode produce `out` high on consecutive enabled cycles. This occurs only when PATTERN is periodic with period 1 (all-0 or all-1).
- There is no combinational path from inputs to outputs.
- With `rst` asserted, every output reads its reset value on the cycle after the edge.

## Structure
- Package `seq_det_pkg`:
  - `typedef enum logic {NON_OVERLAP, OVERLAP} ovl_mode_t`
  - function `fill_w(int n)` returning $clog2(n+1)
- One sub-module, `sat_counter` (parameter WIDTH; ports `clk`, `rst`, `clr`, `inc`, `cnt`, `sat`), instantiated for `match_cnt`/`sat`.
- Top module holds `hist`, `fill`, match compare and `out` register.
- Parameter check: elaboration-time error if PAT_W < 2 or $bits(PATTERN) != PAT_W.

## Test plan
- Default params, `en`=1, `in` = 1,1,0 after reset → `out`=1 for one cycle after the edge sampling 0; `match_cnt`=1. Stream 1,1,1,0 → one match (no false match on 1,1,1).
- PAT_W=4, PATTERN=4'b1010, `in` = 1,0,1,0,1,0,1:
  - `ovl`=1 → 2 matches, on the 4th and 6th bits.
  - `ovl`=0 → 1 match; `match_cnt`=1.
- `en` gaps: 1, (en=0 ×3), 1, (en=0), 0 → one match. `out` stays low during the gaps and pulses once after the final enabled 0.
- `rst` pulse after receiving 1,1, then 0 → no match. Then 1,1,0 → `match_cnt`=1. Check all outputs are 0 in the cycle after reset.
- CNT_W=2, six "110" matches → `match_cnt`=3 and `sat`=1 after the third match, holding. Assert `clr` on the edge of a 7th match → `match_cnt`=1, `sat`=0.
- All-ones PATTERN (PAT_W=3, 3'b111), `ovl`=1, five 1s → `out` high on 3 consecutive cycles. With `ovl`=0 → one match.
